// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative unsigned multiply/divide, one bit per cycle
// Shift-add multiplier and restoring divider share one hi/lo register pair.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int SELW  = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SELW-1:0]  dsel_in,
    output logic             busy,
    output logic             done,
    output logic             we_out,
    output logic [SELW-1:0]  dsel_out,
    output logic [WIDTH-1:0] result
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt;
    logic [1:0]       op_r;
    logic [WIDTH-1:0] opd, lo, lo_n;
    logic [WIDTH:0]   hi, hi_n, mul_acc, shifted, trial;
    logic             accept, last;

    always_ff @(posedge clock)
        if (reset) state <= IDLE;
        else state <= state_n;

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        last    = 1'b0;
        case (state)
            IDLE: if (start) begin
                state_n = RUN;
                accept  = 1'b1;
            end
            RUN: if (cnt == '0) begin
                state_n = DONE;
                last    = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy   = state != IDLE;
    assign done   = state == DONE;
    assign we_out = done;

    // Multiply: hi = running upper product (with carry), lo = multiplier shifting out.
    // Divide: hi = partial remainder, lo = dividend shifting out / quotient shifting in.
    assign mul_acc = lo[0] ? {1'b0, hi[WIDTH-1:0]} + {1'b0, opd} : {1'b0, hi[WIDTH-1:0]};
    assign shifted = {hi[WIDTH-1:0], lo[WIDTH-1]};
    assign trial   = shifted - {1'b0, opd};
    assign hi_n    = op_r[1] ? (trial[WIDTH] ? shifted : trial) : {1'b0, mul_acc[WIDTH:1]};
    assign lo_n    = op_r[1] ? {lo[WIDTH-2:0], ~trial[WIDTH]} : {mul_acc[0], lo[WIDTH-1:1]};

    always_ff @(posedge clock)
        if (reset) begin
            cnt      <= '0;
            op_r     <= '0;
            opd      <= '0;
            hi       <= '0;
            lo       <= '0;
            dsel_out <= '0;
            result   <= '0;
        end else if (accept) begin
            cnt      <= CW'(WIDTH - 1);
            op_r     <= op;
            opd      <= op[1] ? b : a;
            hi       <= '0;
            lo       <= op[1] ? a : b;
            dsel_out <= dsel_in;
        end else if (state == RUN) begin
            cnt <= cnt - 1'b1;
            hi  <= hi_n;
            lo  <= lo_n;
            if (last) result <= op_r[0] ? hi_n[WIDTH-1:0] : lo_n;
        end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors plus a cycle-level arithmetic model of muldiv_unit
module tb_muldiv_unit;
    localparam int W = 32;
    localparam int L = W + 1;

    logic         clock = 0, reset = 1, start = 0;
    logic [1:0]   op = 0;
    logic [31:0]  a = 0, b = 0;
    logic [3:0]   dsel_in = 0;
    logic         busy, done, we_out;
    logic [3:0]   dsel_out;
    logic [31:0]  result;

    int errors = 0, checks = 0;
    bit armed = 0;

    int          m_left = 0;
    logic [31:0] m_res = 0, m_pend = 0;
    logic [3:0]  m_dsel = 0;

    muldiv_unit dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .dsel_in(dsel_in), .busy(busy), .done(done), .we_out(we_out),
        .dsel_out(dsel_out), .result(result)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] ref_op(input logic [1:0] o, input logic [31:0] x, y);
        logic [63:0] p;
        p = {32'b0, x} * {32'b0, y};
        case (o)
            2'd0:    return p[31:0];
            2'd1:    return p[63:32];
            2'd2:    return (y == 0) ? 32'hFFFFFFFF : x / y;
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // m_left: cycles of busy remaining; 1 marks the done cycle
    always @(posedge clock) begin
        if (reset) begin
            m_left <= 0;
            m_res  <= 0;
            m_dsel <= 0;
        end else if (m_left == 0 && start) begin
            m_left <= L;
            m_pend <= ref_op(op, a, b);
            m_dsel <= dsel_in;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 2) m_res <= m_pend;
        end
    end

    always @(negedge clock) if (armed) begin
        chk("busy", busy, m_left != 0);
        chk("done", done, m_left == 1);
        chk("we_out", we_out, m_left == 1);
        chk("result", result, m_res);
        chk("dsel_out", dsel_out, m_dsel);
    end

    task automatic run(input logic [1:0] o, input logic [31:0] x, y, input logic [3:0] d,
                       input logic [31:0] exp, input string name);
        int n;
        op = o; a = x; b = y; dsel_in = d; start = 1;
        @(posedge clock); #1;
        start = 0;
        op = 2'($urandom); a = $urandom; b = $urandom; dsel_in = 4'($urandom);
        for (n = 1; n <= 60; n++) begin
            @(negedge clock);
            if (done) break;
        end
        chk({name, "_latency"}, n, L);
        chk(name, result, exp);
        chk({name, "_dsel"}, dsel_out, d);
        @(posedge clock); #1;
    endtask

    initial begin
        int n, extra;
        start = 1; op = 0; a = 5; b = 5; dsel_in = 9;
        repeat (2) @(posedge clock);
        #1;
        reset = 0; start = 0;
        armed = 1;
        @(negedge clock);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_dsel", dsel_out, 0);
        @(posedge clock); #1;

        run(2'd0, 7, 6, 3, 32'h0000002A, "mullo_7x6");
        run(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'hFFFFFFFE, "mulhi_ff");
        run(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 6, 32'h00000001, "mullo_ff");
        run(2'd2, 100, 7, 1, 14, "divu_100_7");
        run(2'd3, 100, 7, 2, 2, "remu_100_7");
        run(2'd2, 32'h80000000, 1, 4, 32'h80000000, "divu_msb_1");
        run(2'd2, 32'h1234, 0, 7, 32'hFFFFFFFF, "divu_by0");
        run(2'd3, 32'h1234, 0, 8, 32'h00001234, "remu_by0");
        run(2'd0, 123, 0, 9, 0, "mullo_b0");
        run(2'd1, 0, 55, 10, 0, "mulhi_a0");

        op = 2'd0; a = 3; b = 5; dsel_in = 11; start = 1;
        @(posedge clock); #1;
        start = 0;
        repeat (9) @(posedge clock);
        #1;
        start = 1; op = 2'd2; a = 100; b = 7; dsel_in = 2;
        @(posedge clock); #1;
        start = 0;
        for (n = 11; n <= 80; n++) begin
            @(negedge clock);
            if (done) break;
        end
        chk("busy_start_latency", n, L);
        chk("busy_start_result", result, 15);
        chk("busy_start_dsel", dsel_out, 11);
        @(posedge clock); #1;
        extra = 0;
        repeat (40) begin
            @(negedge clock);
            if (done) extra++;
        end
        chk("no_second_done", extra, 0);
        @(posedge clock); #1;

        op = 2'd0; a = 9; b = 9; dsel_in = 12; start = 1;
        @(posedge clock); #1;
        start = 0;
        repeat (19) @(posedge clock);
        #1;
        reset = 1;
        @(posedge clock); #1;
        reset = 0;
        @(negedge clock);
        chk("midrst_busy", busy, 0);
        chk("midrst_result", result, 0);
        chk("midrst_dsel", dsel_out, 0);
        extra = 0;
        repeat (40) begin
            @(negedge clock);
            if (done) extra++;
        end
        chk("midrst_no_done", extra, 0);
        @(posedge clock); #1;
        run(2'd0, 2, 2, 13, 4, "fresh_2x2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative 32-bit unsigned multiply/divide execution unit.
- Sits directly downstream of the register file read ports: consumes the A and B operand outputs.
- Feeds its result back to the register file write port (data, destination select, write enable).
- Used for MUL/DIV-class instructions. The sequencer stalls issue while `busy` is high.

Parameters:
- WIDTH, 32, operand and result width in bits.
- SELW, 4, register-select width; matches the register file select ports.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled on a rising edge while the unit is idle.
- op  input  2  00 MULLO (low word of product), 01 MULHI (high word), 10 DIVU (quotient), 11 REMU (remainder).
- a  input  WIDTH  operand A (multiplicand / dividend), from register file A output.
- b  input  WIDTH  operand B (multiplier / divisor), from register file B output.
- dsel_in  input  SELW  destination register for the result.
- busy  output  1  high from the cycle after accept through the DONE cycle, inclusive.
- done  output  1  one-cycle pulse; result valid.
- we_out  output  1  register file write enable; identical to `done`.
- dsel_out  output  SELW  latched destination select; drives the register file destination select port.
- result  output  WIDTH  registered result; drives the register file data input.

Behaviour:
- One clock domain (`clock`). Synchronous active-high `reset`. Unsigned arithmetic only.
- Reset values: state=IDLE, busy=0, done=0, we_out=0, dsel_out=0, result=0, counter=0, internal accumulators=0.
- States and transitions:
  - IDLE: if start=1 at edge k, latch a, b, op and dsel_in, clear accumulators, load counter=WIDTH-1, go to RUN.
  - RUN: one iteration per cycle. When counter=0 on an edge, go to DONE; otherwise decrement counter.
  - DONE: one cycle. done=we_out=1. Then return to IDLE unconditionally.
- Timing for start accepted at edge k:
  - RUN occupies cycles k+1 .. k+WIDTH.
  - DONE is cycle k+WIDTH+1.
  - busy is high in cycles k+1 .. k+WIDTH+1.
  - Latency from accept to done is WIDTH+1 cycles (33 at the default).
  - Earliest next accept is the edge that ends the DONE cycle's successor, i.e. start high in cycle k+WIDTH+2.
- Multiply: shift-add over a 2*WIDTH product register.
  - Each iteration: if the current multiplier LSB is 1, add the multiplicand into the upper half (with carry).
  - Then shift the whole register right by 1.
  - MULLO returns product[WIDTH-1:0]; MULHI returns product[2*WIDTH-1:WIDTH].
- Divide: restoring division over a WIDTH+1-bit partial remainder.
  - Each iteration: shift in the next dividend MSB, trial-subtract the divisor.
  - If the trial result is non-negative, keep it and set the quotient bit to 1; otherwise restore and set the bit to 0.
- result is written on the edge entering DONE. It holds its value until the next DONE or reset.
- dsel_out is updated at accept and holds until the next accept or reset.
- Operand isolation: a, b, op and dsel_in are ignored after accept; changes mid-operation have no effect.
- start while busy (RUN or DONE) is ignored: no queueing, no restart, no error flag.
- Divide by zero runs the full latency, no exception:
  - DIVU result = all ones (0xFFFFFFFF).
  - REMU result = a.
- Operand b=0 for multiply gives result 0. a=0 gives result 0.
- Reset mid-operation: returns to IDLE on that edge. No done/we_out pulse is emitted. result and dsel_out clear to 0.
- reset and start on the same edge: reset wins; the request is dropped.
- done/we_out is never high for more than one consecutive cycle.

Test Plan:
- Reset, then MULLO a=7 b=6 dsel_in=3, start pulsed at edge k -> busy=1 in cycles k+1..k+33; done=we_out=1 only in cycle k+33; result=0x0000002A; dsel_out=3.
- MULHI then MULLO with a=b=0xFFFFFFFF -> MULHI result=0xFFFFFFFE; MULLO result=0x00000001; each done exactly 33 cycles after its accept.
- DIVU a=100 b=7 -> result=14; REMU same operands -> result=2; DIVU a=0x80000000 b=1 -> result=0x80000000.
- DIVU a=0x1234 b=0 -> result=0xFFFFFFFF; REMU a=0x1234 b=0 -> result=0x00001234; latency unchanged at 33.
- MULLO 3*5 accepted; in cycle 10 pulse start with op=DIVU and change a/b -> request ignored; single done with result=15; no second done within the next 40 cycles.
- MULLO 9*9 accepted; assert reset in cycle 20 -> no done ever pulses; busy=0, result=0, dsel_out=0 after the reset edge; a fresh 2*2 completes with result=4.
